// File: rtl/controlador_jogo.sv
// rtl/controlador_jogo.sv - battleship attack sequencer: confirm debounce, map scan, shot validation, hit/try bookkeeping
module controlador_jogo #(
    parameter int MAX_TENTATIVAS  = 20,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_modo,
    input  logic       i_confirmar,
    input  logic [2:0] i_coord_linha,
    input  logic [2:0] i_coord_coluna,
    output logic [2:0] o_rd_linha,
    output logic [2:0] o_rd_coluna,
    input  logic       i_rd_dado,
    output logic       o_disparo_valido,
    output logic       o_acerto,
    output logic       o_erro_coord,
    output logic [5:0] o_acertos,
    output logic [5:0] o_tentativas_rest,
    output logic [5:0] o_total_navios,
    output logic [2:0] o_estado,
    output logic       o_vitoria,
    output logic       o_derrota
);

    typedef enum logic [2:0] {
        S_DESL  = 3'd0,
        S_PREP  = 3'd1,
        S_CONT  = 3'd2,
        S_ESP   = 3'd3,
        S_VERIF = 3'd4,
        S_VIT   = 3'd5,
        S_DER   = 3'd6
    } estado_t;

    localparam logic [3:0] DB_ULTIMO = 4'(DEBOUNCE_CICLOS - 1);

    estado_t     r_estado;
    logic        r_sync1, r_sync2;
    logic        r_pressionado;
    logic [3:0]  r_db_cnt;
    logic [34:0] r_bitmap;
    logic [2:0]  r_scan_lin, r_scan_col;
    logic [2:0]  r_lat_lin, r_lat_col;
    logic [5:0]  r_total, r_acertos, r_tent;
    logic        r_erro;

    logic        w_press;
    logic        w_fora;
    logic [5:0]  w_idx_esp, w_idx_lat;
    logic [5:0]  w_total_next, w_acertos_next, w_tent_next;

    // Press fires on the sample that completes the run of stable highs.
    assign w_press = !r_pressionado && r_sync2 && (r_db_cnt == DB_ULTIMO);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_pressionado <= 1'b0;
            r_db_cnt      <= 4'd0;
        end else begin
            r_sync1 <= i_confirmar;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_pressionado) begin
                r_db_cnt <= 4'd0;
            end else if (r_db_cnt == DB_ULTIMO) begin
                r_db_cnt      <= 4'd0;
                r_pressionado <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 4'd1;
            end
        end
    end

    assign w_fora       = (i_coord_linha > 3'd6) || (i_coord_coluna > 3'd4);
    assign w_idx_esp    = {3'b000, i_coord_linha} * 6'd5 + {3'b000, i_coord_coluna};
    assign w_idx_lat    = {3'b000, r_lat_lin} * 6'd5 + {3'b000, r_lat_col};
    assign w_total_next = r_total + {5'b00000, i_rd_dado};
    assign w_acertos_next = (i_rd_dado && r_acertos != 6'd63) ? r_acertos + 6'd1 : r_acertos;
    assign w_tent_next  = (r_tent == 6'd0) ? 6'd0 : r_tent - 6'd1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado   <= S_DESL;
            r_bitmap   <= '0;
            r_scan_lin <= 3'd0;
            r_scan_col <= 3'd0;
            r_lat_lin  <= 3'd0;
            r_lat_col  <= 3'd0;
            r_total    <= 6'd0;
            r_acertos  <= 6'd0;
            r_tent     <= 6'd0;
            r_erro     <= 1'b0;
        end else begin
            r_erro <= 1'b0;
            if (i_modo != 2'b10) begin
                r_estado   <= (i_modo == 2'b01) ? S_PREP : S_DESL;
                r_bitmap   <= '0;
                r_scan_lin <= 3'd0;
                r_scan_col <= 3'd0;
                r_total    <= 6'd0;
                r_acertos  <= 6'd0;
                r_tent     <= 6'd0;
            end else begin
                case (r_estado)
                    S_DESL, S_PREP: begin
                        r_estado   <= S_CONT;
                        r_scan_lin <= 3'd0;
                        r_scan_col <= 3'd0;
                        r_total    <= 6'd0;
                        r_acertos  <= 6'd0;
                        r_tent     <= 6'(MAX_TENTATIVAS);
                        r_bitmap   <= '0;
                    end
                    S_CONT: begin
                        r_total <= w_total_next;
                        if (r_scan_lin == 3'd6 && r_scan_col == 3'd4) begin
                            r_estado <= (w_total_next == 6'd0) ? S_VIT : S_ESP;
                        end else if (r_scan_col == 3'd4) begin
                            r_scan_col <= 3'd0;
                            r_scan_lin <= r_scan_lin + 3'd1;
                        end else begin
                            r_scan_col <= r_scan_col + 3'd1;
                        end
                    end
                    S_ESP: begin
                        if (w_press) begin
                            if (w_fora || r_bitmap[w_idx_esp]) begin
                                r_erro <= 1'b1;
                            end else begin
                                r_lat_lin <= i_coord_linha;
                                r_lat_col <= i_coord_coluna;
                                r_estado  <= S_VERIF;
                            end
                        end
                    end
                    S_VERIF: begin
                        r_bitmap[w_idx_lat] <= 1'b1;
                        r_acertos <= w_acertos_next;
                        r_tent    <= w_tent_next;
                        // Victory is tested first so a final-try hit is not a loss.
                        if (w_acertos_next == r_total)
                            r_estado <= S_VIT;
                        else if (w_tent_next == 6'd0)
                            r_estado <= S_DER;
                        else
                            r_estado <= S_ESP;
                    end
                    S_VIT, S_DER: r_estado <= r_estado;
                    default:      r_estado <= S_DESL;
                endcase
            end
        end
    end

    always_comb begin
        o_rd_linha  = 3'd0;
        o_rd_coluna = 3'd0;
        case (r_estado)
            S_CONT: begin
                o_rd_linha  = r_scan_lin;
                o_rd_coluna = r_scan_col;
            end
            S_ESP: begin
                o_rd_linha  = i_coord_linha;
                o_rd_coluna = i_coord_coluna;
            end
            S_VERIF: begin
                o_rd_linha  = r_lat_lin;
                o_rd_coluna = r_lat_col;
            end
            default: begin
                o_rd_linha  = 3'd0;
                o_rd_coluna = 3'd0;
            end
        endcase
    end

    assign o_disparo_valido  = (r_estado == S_VERIF);
    assign o_acerto          = (r_estado == S_VERIF) && i_rd_dado;
    assign o_erro_coord      = r_erro;
    assign o_acertos         = r_acertos;
    assign o_tentativas_rest = r_tent;
    assign o_total_navios    = r_total;
    assign o_estado          = r_estado;
    assign o_vitoria         = (r_estado == S_VIT);
    assign o_derrota         = (r_estado == S_DER);

endmodule

// File: tb/tb_controlador_jogo.sv
// tb/tb_controlador_jogo.sv - directed bench for controlador_jogo (20-try and 3-try instances)
module tb_controlador_jogo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] modo_a = 2'b00, modo_b = 2'b00;
    logic       conf = 1'b0;
    logic [2:0] lin = 3'd0, col = 3'd0;
    logic [63:0] map_a, map_b;

    logic [2:0] rdl_a, rdc_a, est_a, rdl_b, rdc_b, est_b;
    logic       rdd_a, disp_a, hit_a, err_a, vit_a, der_a;
    logic       rdd_b, disp_b, hit_b, err_b, vit_b, der_b;
    logic [5:0] acert_a, tent_a, tot_a, acert_b, tent_b, tot_b;

    int n_checks = 0, n_err = 0;
    int cyc = 0, cnt_disp_a = 0, cnt_err_a = 0, cnt_hit_a = 0, cnt_cont_a = 0, disp_cyc_a = 0;
    int cnt_disp_b = 0, cnt_err_b = 0, cnt_hit_b = 0;
    int press_cyc = 0;
    bit ok;

    always #5 clk = ~clk;

    assign rdd_a = map_a[{3'b000, rdl_a} * 6'd5 + {3'b000, rdc_a}];
    assign rdd_b = map_b[{3'b000, rdl_b} * 6'd5 + {3'b000, rdc_b}];

    controlador_jogo #(.MAX_TENTATIVAS(20), .DEBOUNCE_CICLOS(4)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_modo(modo_a), .i_confirmar(conf),
        .i_coord_linha(lin), .i_coord_coluna(col), .o_rd_linha(rdl_a), .o_rd_coluna(rdc_a),
        .i_rd_dado(rdd_a), .o_disparo_valido(disp_a), .o_acerto(hit_a), .o_erro_coord(err_a),
        .o_acertos(acert_a), .o_tentativas_rest(tent_a), .o_total_navios(tot_a),
        .o_estado(est_a), .o_vitoria(vit_a), .o_derrota(der_a));

    controlador_jogo #(.MAX_TENTATIVAS(3), .DEBOUNCE_CICLOS(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_modo(modo_b), .i_confirmar(conf),
        .i_coord_linha(lin), .i_coord_coluna(col), .o_rd_linha(rdl_b), .o_rd_coluna(rdc_b),
        .i_rd_dado(rdd_b), .o_disparo_valido(disp_b), .o_acerto(hit_b), .o_erro_coord(err_b),
        .o_acertos(acert_b), .o_tentativas_rest(tent_b), .o_total_navios(tot_b),
        .o_estado(est_b), .o_vitoria(vit_b), .o_derrota(der_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (disp_a) begin cnt_disp_a++; disp_cyc_a = cyc; end
        if (hit_a)  cnt_hit_a++;
        if (err_a)  cnt_err_a++;
        if (est_a == 3'd2) cnt_cont_a++;
        if (disp_b) cnt_disp_b++;
        if (hit_b)  cnt_hit_b++;
        if (err_b)  cnt_err_b++;
    end

    typedef struct {
        logic [2:0] l, c;
        int hold;
        int e_disp, e_err, e_hits, e_acert, e_tent, e_est;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] pl, input logic [2:0] pc, input int hold);
        @(negedge clk);
        lin = pl; col = pc; conf = 1'b1; press_cyc = cyc;
        repeat (hold) @(negedge clk);
        conf = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_est(input bit sel_b, input logic [2:0] target, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel_b ? est_b : est_a) == target) begin hit = 1'b1; break; end
        end
    endtask

    initial begin
        map_a = '0; map_a[0] = 1'b1; map_a[17] = 1'b1; map_a[34] = 1'b1;
        map_b = '0; map_b[6] = 1'b1;

        tbl[0] = '{3'd3, 3'd2, 50, 1, 0, 1, 1, 19, 3};
        tbl[1] = '{3'd3, 3'd2, 10, 1, 1, 1, 1, 19, 3};
        tbl[2] = '{3'd7, 3'd0, 10, 1, 2, 1, 1, 19, 3};
        tbl[3] = '{3'd0, 3'd5, 10, 1, 3, 1, 1, 19, 3};
        tbl[4] = '{3'd0, 3'd0, 10, 2, 3, 2, 2, 18, 3};
        tbl[5] = '{3'd6, 3'd4, 10, 3, 3, 3, 3, 17, 5};

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({est_a, rdl_a, rdc_a, disp_a, hit_a, err_a, acert_a, tent_a, tot_a, vit_a, der_a}), 0);
        rst = 1'b0;

        // Map scan of the 20-try instance
        modo_a = 2'b01;
        repeat (2) @(negedge clk);
        chk("prep_state", int'(est_a), 1);
        cnt_cont_a = 0;
        modo_a = 2'b10;
        wait_est(1'b0, 3'd3, 100, ok);
        chk("reach_esp", int'(ok), 1);
        chk("cont_cycles", cnt_cont_a, 35);
        chk("total_navios", int'(tot_a), 3);
        chk("tent_loaded", int'(tent_a), 20);

        for (int i = 0; i < 6; i++) begin
            press(tbl[i].l, tbl[i].c, tbl[i].hold);
            chk($sformatf("v%0d_disp", i), cnt_disp_a, tbl[i].e_disp);
            chk($sformatf("v%0d_err", i), cnt_err_a, tbl[i].e_err);
            chk($sformatf("v%0d_hits", i), cnt_hit_a, tbl[i].e_hits);
            chk($sformatf("v%0d_acertos", i), int'(acert_a), tbl[i].e_acert);
            chk($sformatf("v%0d_tent", i), int'(tent_a), tbl[i].e_tent);
            chk($sformatf("v%0d_estado", i), int'(est_a), tbl[i].e_est);
            if (i == 0) chk("press_latency", disp_cyc_a - press_cyc, 6);
        end
        chk("vitoria_a", int'(vit_a), 1);

        press(3'd1, 3'd0, 10);
        chk("vit_ignores_press", cnt_disp_a, 3);
        chk("vit_holds", int'(est_a), 5);

        // Preparation mode clears progress and the shot bitmap
        modo_a = 2'b01;
        repeat (2) @(negedge clk);
        chk("prep_again", int'(est_a), 1);
        chk("prep_clears", int'({acert_a, tent_a}), 0);
        modo_a = 2'b10;
        wait_est(1'b0, 3'd3, 100, ok);
        chk("reach_esp2", int'(ok), 1);

        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            lin = 3'd2; col = 3'd2; conf = 1'b1;
            repeat (k) @(negedge clk);
            conf = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("glitch_no_disp", cnt_disp_a, 3);
        chk("glitch_no_err", cnt_err_a, 3);

        press(3'd3, 3'd2, 10);
        chk("bitmap_cleared_disp", cnt_disp_a, 4);
        chk("bitmap_cleared_err", cnt_err_a, 3);
        chk("after_clear_acertos", int'(acert_a), 1);
        chk("after_clear_tent", int'(tent_a), 19);

        // Asynchronous reset while in VERIF
        @(negedge clk);
        lin = 3'd4; col = 3'd1; conf = 1'b1;
        wait_est(1'b0, 3'd4, 30, ok);
        chk("reach_verif", int'(ok), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", int'({est_a, rdl_a, rdc_a, disp_a, hit_a, err_a, acert_a, tent_a, tot_a, vit_a, der_a}), 0);
        conf = 1'b0;
        modo_a = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 3-try instance: defeat
        modo_b = 2'b01;
        repeat (2) @(negedge clk);
        modo_b = 2'b10;
        wait_est(1'b1, 3'd3, 100, ok);
        chk("b_reach_esp", int'(ok), 1);
        chk("b_total", int'(tot_b), 1);
        chk("b_tent", int'(tent_b), 3);
        for (int i = 1; i <= 3; i++) press(3'd0, 3'(i), 8);
        chk("b_disp3", cnt_disp_b, 3);
        chk("b_der_state", int'(est_b), 6);
        chk("b_derrota", int'(der_b), 1);
        chk("b_tent0", int'(tent_b), 0);
        press(3'd1, 3'd1, 8);
        chk("b_der_ignores", cnt_disp_b, 3);
        chk("b_der_holds", int'(est_b), 6);

        // 3-try instance: last ship on the final try
        modo_b = 2'b01;
        repeat (2) @(negedge clk);
        modo_b = 2'b10;
        wait_est(1'b1, 3'd3, 100, ok);
        chk("b_reach_esp2", int'(ok), 1);
        press(3'd0, 3'd1, 8);
        press(3'd0, 3'd2, 8);
        press(3'd1, 3'd1, 8);
        chk("b_disp6", cnt_disp_b, 6);
        chk("b_hits", cnt_hit_b, 1);
        chk("b_vit_state", int'(est_b), 5);
        chk("b_vitoria", int'(vit_b), 1);
        chk("b_no_derrota", int'(der_b), 0);
        chk("b_vit_tent", int'(tent_b), 0);
        chk("b_vit_acertos", int'(acert_b), 1);
        chk("b_no_err", cnt_err_b, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
